// File: rtl/puf_race_capture.sv
// puf_race_capture: arbiter-PUF launch sequencer with majority-voted response capture (optional PUF_TIE_RETRY_EN re-launches tied races)
module puf_race_capture #(
  parameter int RESP_BITS = 8,
  parameter int SAMPLES   = 5,
  parameter int TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         race_q0,
  input  logic                         race_q1,
  output logic                         launch,
  output logic [$clog2(RESP_BITS)-1:0] bit_idx,
  output logic                         busy,
  output logic [RESP_BITS-1:0]         resp,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         timeout_err
);
  localparam int              IW    = $clog2(RESP_BITS);
  localparam logic [3:0]      SAMP  = 4'(SAMPLES);
  localparam logic [3:0]      HALF  = 4'(SAMPLES / 2);
  localparam logic [7:0]      TLAST = 8'(TIMEOUT - 1);
  localparam logic [IW-1:0]   BLAST = IW'(RESP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RECOVER, S_NEXT, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [IW-1:0]        r_bit;
  logic [3:0]           r_scnt, r_ones;
  logic [7:0]           r_wcnt;
  logic [RESP_BITS-1:0] r_resp;
  logic                 r_terr;
  logic                 w_hit, w_vote, w_wait_to, w_rec_to, w_vote_ev, w_retry, w_relaunch;

  assign w_hit     = race_q0 | race_q1;
  assign w_vote    = race_q1 & ~race_q0;
  assign w_wait_to = ~w_hit & (r_wcnt == TLAST);
  assign w_rec_to  = r_wcnt == TLAST;
  assign w_vote_ev = w_hit | w_wait_to;

`ifdef PUF_TIE_RETRY_EN
  logic       w_tie;
  logic [1:0] r_retry;
  logic       r_retry_pend;
  assign w_tie      = race_q0 & race_q1;
  assign w_retry    = w_tie & (r_retry != 2'd3);
  assign w_relaunch = r_retry_pend;
`else
  assign w_retry    = 1'b0;
  assign w_relaunch = 1'b0;
`endif

  assign launch      = r_state == S_LAUNCH;
  assign busy        = r_state != S_IDLE;
  assign resp_valid  = r_state == S_DONE;
  assign resp        = r_resp;
  assign timeout_err = r_terr;
  assign bit_idx     = r_bit;

  // State register; async reset aborts any response and kills launch at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = start ? S_LAUNCH : S_IDLE;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT:    w_next = w_vote_ev ? S_RECOVER : S_WAIT;
      S_RECOVER: w_next = (!w_hit || w_rec_to) ? (w_relaunch ? S_LAUNCH : S_NEXT) : S_RECOVER;
      S_NEXT:    w_next = (r_scnt < SAMP || r_bit != BLAST) ? S_LAUNCH : S_DONE;
      S_DONE:    w_next = resp_ready ? S_IDLE : S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Sample voting, majority resolution and response assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit  <= '0;
      r_scnt <= '0;
      r_ones <= '0;
      r_wcnt <= '0;
      r_resp <= '0;
      r_terr <= 1'b0;
`ifdef PUF_TIE_RETRY_EN
      r_retry      <= '0;
      r_retry_pend <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_resp <= '0;
          r_terr <= 1'b0;
          r_bit  <= '0;
          r_scnt <= '0;
          r_ones <= '0;
        end
        S_LAUNCH: r_wcnt <= '0;
        S_WAIT: if (w_vote_ev) begin
          r_wcnt <= '0;
          if (w_wait_to) r_terr <= 1'b1;
          if (!w_retry) begin
            r_scnt <= r_scnt + 4'd1;
            r_ones <= r_ones + {3'b0, w_vote};
          end
`ifdef PUF_TIE_RETRY_EN
          r_retry_pend <= w_retry;
          r_retry      <= w_retry ? r_retry + 2'd1 : 2'd0;
`endif
        end else r_wcnt <= r_wcnt + 8'd1;
        S_RECOVER: if (w_hit) begin
          if (w_rec_to) r_terr <= 1'b1;
          else r_wcnt <= r_wcnt + 8'd1;
        end
        S_NEXT: if (r_scnt >= SAMP) begin
          r_resp[r_bit] <= r_ones > HALF;
          r_scnt <= '0;
          r_ones <= '0;
          if (r_bit != BLAST) r_bit <= r_bit + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_race_capture.sv
// tb_puf_race_capture: scoreboard bench driving a modelled delay chain into puf_race_capture
module tb_puf_race_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       race_q0 = 1'b0;
  logic       race_q1 = 1'b0;
  logic       resp_ready = 1'b1;
  logic       launch, busy, resp_valid, timeout_err;
  logic [2:0] bit_idx;
  logic [7:0] resp;

  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;
  int launches = 0;
  int k = 0;
  logic l_seen = 1'b0;
  logic [7:0] sb[$];
  int lq[$];

  puf_race_capture dut (
    .clk(clk), .rst_n(rst_n), .start(start), .race_q0(race_q0), .race_q1(race_q1),
    .launch(launch), .bit_idx(bit_idx), .busy(busy), .resp(resp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic bit win1(int n);
    int b = n / 5;
    int s = n % 5;
    return (b % 2 == 0) ? (s < 3) : (s < 2);
  endfunction

  function automatic logic [7:0] model_resp(int m);
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++) begin
      int ones = 0;
      for (int s = 0; s < 5; s++) ones += (m == 1 || (m == 2 && win1(b * 5 + s))) ? 1 : 0;
      r[b] = ones > 2;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    l_seen = launch;
    if (launch) begin
      launches++;
      lq.push_back(int'(bit_idx));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (l_seen) k = 1;
      else if (k != 0) k++;
      if (k == 1 && mode != 0) begin
        race_q1 = (mode == 1) || (mode == 3) || (mode == 2 && win1(launches - 1));
        race_q0 = (mode == 3) || (mode == 2 && !win1(launches - 1));
      end else begin
        race_q1 = 1'b0;
        race_q0 = 1'b0;
      end
    end
  end

  task automatic do_start(input int m);
    mode = m;
    launches = 0;
    lq.delete();
    sb.push_back(model_resp(m));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int lat, output int first_l);
    lat = -1;
    first_l = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (launch && first_l < 0) first_l = c;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({launch, busy, resp_valid, timeout_err} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b expected 0000", {launch, busy, resp_valid, timeout_err}); end
    n_cmp++; if (resp !== 8'h00) begin n_bad++; $display("FAIL reset_resp: got %h expected 00", resp); end
    n_cmp++; if (bit_idx !== 3'd0) begin n_bad++; $display("FAIL reset_bit_idx: got %0d expected 0", bit_idx); end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    launches = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (launches !== 0) begin n_bad++; $display("FAIL reset_no_launch: got %0d expected 0", launches); end
  endtask

  task automatic test_all_ones;
    int lat, fl, bad;
    logic [7:0] exp;
    resp_ready = 1'b1;
    do_start(1);
    wait_valid(400, lat, fl);
    n_cmp++; if (fl !== 1) begin n_bad++; $display("FAIL ones_first_launch: got %0d expected 1", fl); end
    n_cmp++; if (lat !== 161) begin n_bad++; $display("FAIL ones_latency: got %0d expected 161", lat); end
    exp = sb.pop_front();
    n_cmp++; if (resp !== exp) begin n_bad++; $display("FAIL ones_resp: got %h expected %h", resp, exp); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL ones_terr: got %b expected 0", timeout_err); end
    n_cmp++; if (launches !== 40) begin n_bad++; $display("FAIL ones_launches: got %0d expected 40", launches); end
    bad = 0;
    for (int i = 0; i < lq.size(); i++) if (lq[i] != i / 5) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ones_bit_idx: got %0d wrong expected 0 wrong", bad); end
    @(negedge clk);
    n_cmp++; if ({resp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL ones_handshake: got %b expected 00", {resp_valid, busy}); end
  endtask

  task automatic test_pattern55;
    int lat, fl;
    logic [7:0] exp;
    do_start(2);
    wait_valid(400, lat, fl);
    n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL p55_valid: got timeout expected resp_valid"); end
    exp = sb.pop_front();
    n_cmp++; if (resp !== exp || exp !== 8'h55) begin n_bad++; $display("FAIL p55_resp: got %h expected %h", resp, exp); end
    n_cmp++; if (launches !== 40) begin n_bad++; $display("FAIL p55_launches: got %0d expected 40", launches); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat, fl;
    logic [7:0] exp;
    do_start(0);
    wait_valid(1000, lat, fl);
    n_cmp++; if (lat !== 721) begin n_bad++; $display("FAIL to_latency: got %0d expected 721", lat); end
    exp = sb.pop_front();
    n_cmp++; if (resp !== exp) begin n_bad++; $display("FAIL to_resp: got %h expected %h", resp, exp); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_terr: got %b expected 1", timeout_err); end
    n_cmp++; if (launches !== 40) begin n_bad++; $display("FAIL to_launches: got %0d expected 40", launches); end
    @(negedge clk);
  endtask

  task automatic test_ties;
    int lat, fl, exp_l;
    logic [7:0] exp;
`ifdef PUF_TIE_RETRY_EN
    exp_l = 160;
`else
    exp_l = 40;
`endif
    do_start(3);
    wait_valid(1000, lat, fl);
    n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL tie_valid: got timeout expected resp_valid"); end
    exp = sb.pop_front();
    n_cmp++; if (resp !== exp) begin n_bad++; $display("FAIL tie_resp: got %h expected %h", resp, exp); end
    n_cmp++; if (launches !== exp_l) begin n_bad++; $display("FAIL tie_launches: got %0d expected %0d", launches, exp_l); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tie_terr: got %b expected 0", timeout_err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, fl;
    logic [7:0] exp;
    resp_ready = 1'b0;
    do_start(1);
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(400, lat, fl);
    n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL bp_valid: got timeout expected resp_valid"); end
    exp = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      start = (i == 5);
      n_cmp++; if ({resp_valid, resp} !== {1'b1, exp}) begin n_bad++; $display("FAIL bp_hold%0d: got %b/%h expected 1/%h", i, resp_valid, resp, exp); end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++; if (launches !== 40) begin n_bad++; $display("FAIL bp_launches: got %0d expected 40", launches); end
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({resp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL bp_release: got %b expected 00", {resp_valid, busy}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({launches, resp} !== {32'd40, exp}) begin n_bad++; $display("FAIL bp_idle_keep: got %0d/%h expected 40/%h", launches, resp, exp); end
  endtask

  task automatic test_reset_in_wait;
    int c;
    do_start(1);
    for (c = 0; c < 300 && launches < 12; c++) begin
      @(negedge clk);
      #1;
    end
    mode = 0;
    n_cmp++; if (launches !== 12) begin n_bad++; $display("FAIL rw_reach: got %0d expected 12", launches); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, launch, bit_idx, resp} !== 13'd0) begin n_bad++; $display("FAIL rw_async: got %b/%b/%0d/%h expected 0/0/0/00", busy, launch, bit_idx, resp); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (launch !== 1'b0) begin n_bad++; $display("FAIL rl_async: got %b expected 0", launch); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern55();
    test_timeout();
    test_ties();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
